// File: rtl/pad_cfg_ctrl.sv
// Per-pad config registers driving gf180mcu pad controls, plus input synchronisers and glitch filters.
// Latency: pad controls 1 cycle after cfg/core_out; raw pad -> core_in SYNC_STAGES+1 (unfiltered); no backpressure.
module pad_cfg_ctrl #(
  parameter int NUM_INPUT_PADS = 4,
  parameter int NUM_BIDIR_PADS = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 8,
  parameter int AW             = 6
) (
  input  logic                      clk60,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [AW-1:0]             cfg_addr,
  input  logic [7:0]                cfg_wdata,
  output logic [7:0]                cfg_rdata,
  input  logic [NUM_BIDIR_PADS-1:0] core_out,
  output logic [NUM_BIDIR_PADS-1:0] core_in,
  output logic [NUM_INPUT_PADS-1:0] input_val,
  input  logic [NUM_BIDIR_PADS-1:0] bidir_in,
  output logic [NUM_BIDIR_PADS-1:0] bidir_out,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
  input  logic [NUM_INPUT_PADS-1:0] input_in,
  output logic [NUM_INPUT_PADS-1:0] input_pu,
  output logic [NUM_INPUT_PADS-1:0] input_pd
);

  localparam int NB = NUM_BIDIR_PADS;
  localparam int NI = NUM_INPUT_PADS;
  localparam int NP = NB + NI;
  localparam int CW = $clog2(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

  logic [6:0]             r_bcfg [NB];
  logic [4:0]             r_icfg [NI];
  logic [7:0]             r_rdata;
  logic [SYNC_STAGES-1:0] r_sync [NP];
  logic [CW-1:0]          r_cnt  [NP];
  logic [NP-1:0]          r_val;

  logic [NB-1:0] w_bsel;
  logic [NI-1:0] w_isel;
  logic [7:0]    w_rdata;
  logic [NP-1:0] w_raw;
  logic [NP-1:0] w_fen;
  logic [NP-1:0] w_fclr;
  logic          w_unused_wdata;

  assign w_unused_wdata = cfg_wdata[7];
  assign w_raw          = {input_in, bidir_in};
  assign cfg_rdata      = r_rdata;
  assign core_in        = r_val[NB-1:0];
  assign input_val      = r_val[NP-1:NB];

  // {pu, pd} for a pull field; keeper follows the filtered pad value.
  function automatic logic [1:0] f_pull(input logic [1:0] pull, input logic val);
    case (pull)
      2'b01:   f_pull = 2'b10;
      2'b10:   f_pull = 2'b01;
      2'b11:   f_pull = {val, ~val};
      default: f_pull = 2'b00;
    endcase
  endfunction

  always_comb begin
    w_rdata = '0;
    w_fen   = '0;
    w_fclr  = '0;
    for (int b = 0; b < NB; b++) begin
      w_bsel[b] = (int'(cfg_addr) == b);
      w_fen[b]  = r_bcfg[b][6];
      w_fclr[b] = cfg_we && w_bsel[b] && (cfg_wdata[6] != r_bcfg[b][6]);
      if (w_bsel[b]) w_rdata = {1'b0, r_bcfg[b]};
    end
    for (int i = 0; i < NI; i++) begin
      w_isel[i]    = (int'(cfg_addr) == NB + i);
      w_fen[NB+i]  = r_icfg[i][4];
      w_fclr[NB+i] = cfg_we && w_isel[i] && (cfg_wdata[6] != r_icfg[i][4]);
      if (w_isel[i]) w_rdata = {1'b0, r_icfg[i], 2'b00};
    end
  end

  // Read data is sampled before the write lands, so same-cycle read returns the old value.
  always_ff @(posedge clk60) begin
    if (rst) begin
      r_rdata <= '0;
      for (int b = 0; b < NB; b++) r_bcfg[b] <= '0;
      for (int i = 0; i < NI; i++) r_icfg[i] <= '0;
    end else begin
      r_rdata <= w_rdata;
      for (int b = 0; b < NB; b++)
        if (cfg_we && w_bsel[b]) r_bcfg[b] <= cfg_wdata[6:0];
      for (int i = 0; i < NI; i++)
        if (cfg_we && w_isel[i]) r_icfg[i] <= cfg_wdata[6:2];
    end
  end

  always_ff @(posedge clk60) begin
    if (rst) begin
      r_val <= '0;
      for (int p = 0; p < NP; p++) begin
        r_sync[p] <= '0;
        r_cnt[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        r_sync[p] <= {r_sync[p][SYNC_STAGES-2:0], w_raw[p]};
        if (!w_fen[p]) begin
          r_val[p] <= r_sync[p][SYNC_STAGES-1];
          r_cnt[p] <= '0;
        end else if (r_sync[p][SYNC_STAGES-1] == r_val[p]) begin
          r_cnt[p] <= '0;
        end else if (r_cnt[p] == CNT_MAX) begin
          r_val[p] <= r_sync[p][SYNC_STAGES-1];
          r_cnt[p] <= '0;
        end else begin
          r_cnt[p] <= r_cnt[p] + 1'b1;
        end
        if (w_fclr[p]) r_cnt[p] <= '0;
      end
    end
  end

  always_ff @(posedge clk60) begin
    if (rst) begin
      bidir_out <= '0;
      bidir_oe  <= '0;
      bidir_cs  <= '0;
      bidir_sl  <= '0;
      bidir_ie  <= '1;
      bidir_pu  <= '0;
      bidir_pd  <= '0;
      input_pu  <= '0;
      input_pd  <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        bidir_cs[b] <= r_bcfg[b][4];
        bidir_sl[b] <= r_bcfg[b][5];
        case (r_bcfg[b][1:0])
          2'b00: begin
            bidir_out[b] <= 1'b0;
            bidir_oe[b]  <= 1'b0;
            bidir_ie[b]  <= 1'b1;
          end
          2'b01: begin
            bidir_out[b] <= core_out[b];
            bidir_oe[b]  <= 1'b1;
            bidir_ie[b]  <= 1'b1;
          end
          2'b10: begin
            bidir_out[b] <= 1'b0;
            bidir_oe[b]  <= ~core_out[b];
            bidir_ie[b]  <= 1'b1;
          end
          default: begin
            bidir_out[b] <= 1'b0;
            bidir_oe[b]  <= 1'b0;
            bidir_ie[b]  <= 1'b0;
          end
        endcase
        if (r_bcfg[b][1:0] == 2'b11)
          {bidir_pu[b], bidir_pd[b]} <= 2'b00;
        else
          {bidir_pu[b], bidir_pd[b]} <= f_pull(r_bcfg[b][3:2], r_val[b]);
      end
      for (int i = 0; i < NI; i++)
        {input_pu[i], input_pd[i]} <= f_pull(r_icfg[i][1:0], r_val[NB+i]);
    end
  end

endmodule
